expression_dispatcher: RTL and testbench
========================================

// Module: expression_dispatcher
// PURPOSE
//   Upstream feeder for expression_solver. Buffers operand jobs (X,A,B,C) from a valid/ready
//   source in a FIFO, issues one job at a time via sol_start, waits for sol_completed, and
//   presents the result and flags on a valid/ready output. Serialises back-to-back requests.
// PARAMETERS
//   DATA_WIDTH      16  width of A, B, C and result (signed)
//   X_WIDTH         8   width of X (signed)
//   DEPTH           4   job FIFO entries, power of two, >= 2
//   TIMEOUT_CYCLES  64  WAIT-state cycle limit (used only with JOB_TIMEOUT_EN)
// PORTS
//   clk           in   1              clock, rising edge
//   rst           in   1              reset, asynchronous, active-low
//   in_valid      in   1              job offered
//   in_ready      out  1              job FIFO has space
//   in_x          in   X_WIDTH        job operand X
//   in_a/b/c      in   DATA_WIDTH     job operands A, B, C
//   sol_start     out  1              solver start, held high for the job duration
//   sol_x         out  X_WIDTH        operand X to solver
//   sol_a/b/c     out  DATA_WIDTH     operands A, B, C to solver
//   sol_result    in   DATA_WIDTH     solver result
//   sol_zero      in   1              solver zero flag
//   sol_overflow  in   1              solver overflow flag
//   sol_completed in   1              solver done
//   out_valid     out  1              result held for consumer
//   out_ready     in   1              consumer accepts
//   out_result    out  DATA_WIDTH     captured result
//   out_zero      out  1              captured zero flag
//   out_overflow  out  1              captured overflow flag
//   out_timeout   out  1              job aborted by watchdog
//   busy          out  1              state != IDLE
//   fifo_count    out  $clog2(DEPTH)+1  entries queued
// BEHAVIOUR
//   Reset (rst=0, async): IDLE, FIFO empty, all outputs 0 except in_ready=1; queued and
//     in-flight jobs are discarded, sol_start drops immediately.
//   FIFO: push on in_valid&&in_ready; in_ready = (fifo_count<DEPTH), registered, not
//     dependent on same-cycle pop. Push+pop in one cycle: count unchanged. Pointers wrap
//     mod DEPTH. Data at in_* while in_ready=0 is ignored.
//   FSM: IDLE -> ISSUE when fifo_count!=0 && sol_completed==0; pops head into sol_x/a/b/c
//     (registered, stable until next pop).
//     ISSUE (1 cycle): sol_start=1; sol_completed ignored. -> WAIT.
//     WAIT: sol_start=1; on sol_completed=1 capture sol_result/zero/overflow into out_*,
//     out_timeout=0 -> HOLD.
//     HOLD: sol_start=0, out_valid=1, out_* stable; on out_ready -> IDLE, out_valid=0.
//   Latency: job pushed at cycle N into empty idle block -> sol_start=1 at N+2.
//     sol_completed seen at cycle M -> out_valid=1 at M+1.
//   sol_start is low >= 1 cycle between jobs (HOLD); IDLE does not issue while
//     sol_completed is still high from the previous job.
//   out_valid stays high with out_ready=0 indefinitely; FIFO keeps accepting meanwhile.
//   No arithmetic; widths pass through unchanged, signed values are not re-extended.
// CONFIGURATION
//   JOB_TIMEOUT_EN defined: cycle counter cleared on ISSUE, increments in WAIT; reaching
//     TIMEOUT_CYCLES without sol_completed -> HOLD with out_result=0, out_zero=0,
//     out_overflow=0, out_timeout=1. sol_completed in the same cycle wins (normal capture).
//   Not defined: WAIT has no limit; out_timeout tied 0; no counter logic.
// TESTING  (bench solver model: result=A*X*X+B*X+C, completed 5 cycles after start rises)
//   Single job X=1,A=B=C=3 -> sol_start 2 cycles after push, out_result=9, zero=0, ovf=0.
//   Job X=0,A=5,B=7,C=0 -> out_result=0, out_zero=1.
//   Push 5 jobs back-to-back, DEPTH=4, no pops possible -> in_ready=0 at count 4; all
//     accepted jobs emerge in order with correct results, sol_start low between jobs.
//   out_ready held 0 for 20 cycles after first result -> out_* stable, fifo_count rises.
//   rst low during WAIT with 2 jobs queued -> sol_start=0, out_valid=0, fifo_count=0.
//   JOB_TIMEOUT_EN, TIMEOUT_CYCLES=8, model never completes -> out_timeout=1, out_result=0
//     after 8 WAIT cycles; next job then completes normally with out_timeout=0.

Source files
------------

// File: rtl/expression_dispatcher.sv
// expression_dispatcher: job FIFO feeding expression_solver, one job in flight.
// Optional solver watchdog in WAIT is enabled by defining JOB_TIMEOUT_EN.
module expression_dispatcher #(
  parameter int DATA_WIDTH     = 16,
  parameter int X_WIDTH        = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [X_WIDTH-1:0]      in_x,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic [DATA_WIDTH-1:0]   in_c,
  output logic                    sol_start,
  output logic [X_WIDTH-1:0]      sol_x,
  output logic [DATA_WIDTH-1:0]   sol_a,
  output logic [DATA_WIDTH-1:0]   sol_b,
  output logic [DATA_WIDTH-1:0]   sol_c,
  input  logic [DATA_WIDTH-1:0]   sol_result,
  input  logic                    sol_zero,
  input  logic                    sol_overflow,
  input  logic                    sol_completed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic                    out_zero,
  output logic                    out_overflow,
  output logic                    out_timeout,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [X_WIDTH-1:0]    x;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] c;
  } job_t;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, HOLD
  } state_t;

  state_t        state_q, state_d;
  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic          in_ready_q;
  logic          push, pop, fin, tmo_hit;

  assign push = in_valid && in_ready_q;
  assign pop  = (state_q == IDLE) && (count != '0)
             && !sol_completed;
  assign fin  = (state_q == WAIT)
             && (sol_completed || tmo_hit);

  always_comb begin
    count_d = count;
    unique case (1'b1)
      push && !pop: count_d = count + 1'b1;
      pop && !push: count_d = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{in_x, in_a, in_b, in_c};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_d;
      in_ready_q <= (count_d < FULL);
    end
  end

  // Operands stay on the solver bus until the next pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sol_x <= '0;
      sol_a <= '0;
      sol_b <= '0;
      sol_c <= '0;
    end else if (pop) begin
      sol_x <= mem[rd_ptr].x;
      sol_a <= mem[rd_ptr].a;
      sol_b <= mem[rd_ptr].b;
      sol_c <= mem[rd_ptr].c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (fin) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A completion in the watchdog's last cycle still wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
    end else if (fin) begin
      out_result   <= sol_completed ? sol_result : '0;
      out_zero     <= sol_completed && sol_zero;
      out_overflow <= sol_completed && sol_overflow;
    end
  end

`ifdef JOB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  wcnt <= '0;
    else if (state_q == ISSUE) wcnt <= '0;
    else if (state_q == WAIT)  wcnt <= wcnt + 1'b1;
  end

  assign tmo_hit = (state_q == WAIT) && (wcnt == TLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     out_timeout <= 1'b0;
    else if (fin) out_timeout <= !sol_completed;
  end
`else
  assign tmo_hit     = 1'b0;
  assign out_timeout = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign fifo_count = count;
  assign sol_start  = (state_q == ISSUE) || (state_q == WAIT);
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_expression_dispatcher.sv
// Directed bench for expression_dispatcher with a behavioural solver model.
// Expected results are queued on job acceptance and checked at the handshake.
module tb_expression_dispatcher;

  localparam int DW    = 16;
  localparam int XW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_x = '0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [DW-1:0] in_c = '0;

  logic          sol_start;
  logic [XW-1:0] sol_x;
  logic [DW-1:0] sol_a, sol_b, sol_c;
  logic [DW-1:0] sol_result    = '0;
  logic          sol_zero      = 1'b0;
  logic          sol_overflow  = 1'b0;
  logic          sol_completed = 1'b0;

  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_result;
  logic          out_zero, out_overflow, out_timeout, busy;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct packed {
    logic [DW-1:0] r;
    logic          z;
    logic          v;
    logic          t;
  } res_t;

  res_t exp_q[$];
  res_t mr;
  int   ntests = 0;
  int   nfail  = 0;
  int   nres   = 0;
  int   mcnt   = 0;
  logic nocomp = 1'b0;

  expression_dispatcher #(
    .DATA_WIDTH(DW), .X_WIDTH(XW),
    .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .sol_start(sol_start), .sol_x(sol_x),
    .sol_a(sol_a), .sol_b(sol_b), .sol_c(sol_c),
    .sol_result(sol_result), .sol_zero(sol_zero),
    .sol_overflow(sol_overflow),
    .sol_completed(sol_completed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_overflow(out_overflow),
    .out_timeout(out_timeout),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic res_t calc(
    input logic signed [XW-1:0] x,
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b,
    input logic signed [DW-1:0] c
  );
    longint f;
    res_t   o;
    f = longint'(a) * longint'(x) * longint'(x)
      + longint'(b) * longint'(x) + longint'(c);
    o.r = f[DW-1:0];
    o.z = (o.r == '0);
    o.v = (f > 32767) || (f < -32768);
    o.t = 1'b0;
    return o;
  endfunction

  // Solver: completes 5 cycles after start rises, holds until start drops.
  always @(posedge clk) begin
    if (!sol_start) begin
      mcnt          <= 0;
      sol_completed <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt == 4 && !nocomp) begin
        mr = calc(sol_x, sol_a, sol_b, sol_c);
        sol_result    <= mr.r;
        sol_zero      <= mr.z;
        sol_overflow  <= mr.v;
        sol_completed <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic step();
    logic acc, hs;
    res_t e, n;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_result", out_result, e.r);
        chk("out_zero", out_zero, e.z);
        chk("out_overflow", out_overflow, e.v);
        chk("out_timeout", out_timeout, e.t);
        chk("start_gap", sol_start, 0);
        nres++;
      end
    end
    if (acc) begin
      if (nocomp) n = '{r: '0, z: 1'b0, v: 1'b0, t: 1'b1};
      else        n = calc(in_x, in_a, in_b, in_c);
      exp_q.push_back(n);
    end
    @(posedge clk);
    #1;
    if (acc) in_valid = 1'b0;
  endtask

  task automatic push(input logic [XW-1:0] x,
                      input logic [DW-1:0] a,
                      input logic [DW-1:0] b,
                      input logic [DW-1:0] c);
    in_x = x; in_a = a; in_b = b; in_c = c;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && in_valid; i++) step();
    if (in_valid) begin
      chk("push_accept", in_valid, 0);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input int budget, output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  initial begin
    int   cyc;
    int   base;
    logic [DW-1:0] hold;
    logic stable;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sol_start", sol_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_timeout", out_timeout, 0);
    rst = 1'b1;
    step();

    push(8'sd1, 16'sd3, 16'sd3, 16'sd3);
    chk("lat_start_n1", sol_start, 0);
    step();
    chk("lat_start_n2", sol_start, 1);
    chk("lat_busy", busy, 1);
    wait_out(100, cyc);
    chk("lat_out", cyc, 6);
    chk("res_9", out_result, 9);
    step();
    chk("out_valid_clr", out_valid, 0);

    push(8'sd0, 16'sd5, 16'sd7, 16'sd0);
    wait_out(100, cyc);
    chk("zero_flag", out_zero, 1);
    step();

    push(-8'sd2, 16'sd100, -16'sd3, 16'sd7);
    wait_out(100, cyc);
    step();

    push(8'sd100, 16'sd10, 16'sd0, 16'sd0);
    wait_out(100, cyc);
    chk("ovf_flag", out_overflow, 1);
    step();

    out_ready = 1'b0;
    base = nres;
    push(8'sd2, 16'sd1, 16'sd1, 16'sd1);
    wait_out(100, cyc);
    hold = out_result;
    chk("bp_first", out_result, 7);
    push(8'sd1, 16'sd1, 16'sd2, 16'sd3);
    push(-8'sd1, 16'sd4, 16'sd5, 16'sd6);
    push(8'sd3, -16'sd2, 16'sd0, 16'sd1);
    push(8'sd5, 16'sd0, 16'sd0, 16'sd0);
    chk("bp_count", fifo_count, 4);
    chk("bp_in_ready", in_ready, 0);
    in_x = 8'sd4; in_a = 16'sd2;
    in_b = -16'sd1; in_c = 16'sd9;
    in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_result !== hold || out_valid !== 1'b1
          || sol_start !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_count_held", fifo_count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 600 &&
         (exp_q.size() != 0 || in_valid); i++)
      step();
    chk("bp_results", nres, base + 6);
    chk("bp_drained", exp_q.size(), 0);

    push(8'sd1, 16'sd1, 16'sd1, 16'sd1);
    push(8'sd2, 16'sd2, 16'sd2, 16'sd2);
    push(8'sd3, 16'sd3, 16'sd3, 16'sd3);
    chk("rw_count", fifo_count, 2);
    chk("rw_start", sol_start, 1);
    rst = 1'b0;
    #1;
    chk("rw_sol_start", sol_start, 0);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_count0", fifo_count, 0);
    chk("rw_busy", busy, 0);
    exp_q.delete();
    step();
    rst = 1'b1;
    step();
    chk("rw_idle", sol_start, 0);
    chk("rw_in_ready", in_ready, 1);

    push(8'sd3, -16'sd1, 16'sd2, -16'sd5);
    wait_out(100, cyc);
    chk("neg_result", out_result, 16'hfff8);
    step();

`ifdef JOB_TIMEOUT_EN
    nocomp = 1'b1;
    push(8'sd1, 16'sd1, 16'sd1, 16'sd1);
    step();
    wait_out(100, cyc);
    chk("tmo_lat", cyc, TMO + 1);
    chk("tmo_flag", out_timeout, 1);
    step();
    nocomp = 1'b0;
    push(8'sd2, 16'sd0, 16'sd3, 16'sd1);
    wait_out(100, cyc);
    chk("tmo_clear", out_timeout, 0);
    step();
`endif

    chk("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
